time_report_uart_tx: RTL
========================

// Module: time_report_uart_tx
// PURPOSE
//  Serial-transmit side of the clock's UART link: on request, snapshots the current Hour/Min/Sec
//  and sends them as ASCII "HH:MM:SS\r\n" over an 8N1 UART line. Counterpart of the UART-set
//  path into the alarm/clock registers; sits beside the time counter, driving the board TX pin.
// PARAMETERS
//  CLK_FREQ  50_000_000  clk frequency in Hz
//  BAUD      9600        line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD clk cycles per bit (>=2)
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  reset     in   1  asynchronous, active-low reset
//  send      in   1  request; sampled each posedge, level or pulse
//  Hour_in   in   7  current hour, binary
//  Min_in    in   7  current minute, binary
//  Sec_in    in   7  current second, binary
//  tx        out  1  UART serial output, idle high
//  busy      out  1  high while a message is in progress
//  done      out  1  one-cycle pulse after the final stop bit of the message
// BEHAVIOUR
//  - Reset (async, !reset): tx=1, busy=0, done=0, FSM=IDLE, all counters 0. Reset mid-frame
//    aborts at once; line returns high and no partial char is resumed.
//  - FSM: IDLE -> START -> DATA -> STOP -> (next char ? START : FIN) ; FIN -> IDLE.
//  - IDLE: send=1 at edge N latches Hour_in/Min_in/Sec_in into snapshot regs, char index=0;
//    at edge N, busy=1 and state=START, so tx=0 is visible from edge N onward (registered tx).
//  - send while busy is ignored (no queueing); input changes after snapshot do not affect output.
//  - Each bit lasts exactly BAUD_DIV cycles (baud counter 0..BAUD_DIV-1, reloads per bit).
//  - START: tx=0 one bit. DATA: 8 bits LSB first from shift reg. STOP: tx=1 one bit.
//  - Char sequence (index 0..9): tens(H), units(H), ':', tens(M), units(M), ':', tens(S),
//    units(S), 8'h0D, 8'h0A. Digit char = 8'h30 + digit.
//  - Binary->decimal: tens = v/10, units = v%10 for v<=99; v>=100 saturates to "99".
//    No range check against 23/59; values are sent as given.
//  - After stop bit of last char: FIN for 1 cycle: done=1, busy=0 the following edge -> IDLE.
//    A send sampled in that IDLE cycle starts a new message immediately (back-to-back allowed).
//  - Message length: 10 chars x 10 bits x BAUD_DIV cycles; busy high for that +1 (FIN) cycles.
//  - tx, busy, done are registered outputs; no combinational path from inputs to outputs.
// CONFIGURATION
//  TIME_TX_ALARM_TAG_EN  defined: extra input alarm_on (1 bit); its value is snapshotted with
//    the time; if 1, char '*' (8'h2A) is inserted between units(S) and 8'h0D (11 chars).
//  Not defined: no alarm_on port; message is always exactly the 10 chars above.
// TESTING  (override CLK_FREQ=160, BAUD=10 -> BAUD_DIV=16)
//  1 Reset: assert reset=0 mid-DATA -> tx=1, busy=0, done=0 same cycle; release -> stays IDLE.
//  2 Hour_in=23,Min_in=59,Sec_in=30, pulse send -> decoded bytes 32 33 3A 35 39 3A 33 30 0D 0A,
//    every bit 16 cycles, start bit 0 / stop bit 1, done pulse once after 1600 cycles.
//  3 Hour_in=0,Min_in=5,Sec_in=9 -> "00:05:09\r\n"; Sec_in=127 -> seconds sent as "99".
//  4 send held high for 2000 cycles -> exactly two messages back-to-back, no gap beyond FIN/IDLE;
//    change Sec_in during message -> first message carries snapshot value.
//  5 pulse send while busy -> ignored, single done pulse, byte count 10.
//  6 TIME_TX_ALARM_TAG_EN defined, alarm_on=1 -> 11 bytes with 2A before 0D; alarm_on=0 -> 10.

Source files
------------

// File: rtl/time_report_uart_tx.sv
// Sends a snapshot of Hour/Min/Sec as ASCII "HH:MM:SS\r\n" over an 8N1 UART line on request.
// Optional build macro TIME_TX_ALARM_TAG_EN adds alarm_on and inserts '*' before CR when it is set.
module time_report_uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [6:0] Hour_in,
  input  logic [6:0] Min_in,
  input  logic [6:0] Sec_in,
`ifdef TIME_TX_ALARM_TAG_EN
  input  logic       alarm_on,
`endif
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [3:0]       char_idx_r;
  logic [7:0]       shift_r;
  logic [6:0]       hour_r;
  logic [6:0]       min_r;
  logic [6:0]       sec_r;
  logic             tag_s;
  logic [7:0]       char_s;
  logic [3:0]       last_idx_s;
  logic [3:0]       pos_s;
  logic [7:0]       hour_dec_s;
  logic [7:0]       min_dec_s;
  logic [7:0]       sec_dec_s;
  logic             bit_end_s;

  // Binary 0..127 to packed {tens, units}; anything past 99 clamps to 99.
  function automatic logic [7:0] dec_digits(input logic [6:0] v);
    logic [7:0] result;
    if (v >= 7'd100) begin
      result = {4'd9, 4'd9};
    end else begin
      result = {4'(v / 7'd10), 4'(v % 7'd10)};
    end
    return result;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

`ifdef TIME_TX_ALARM_TAG_EN
  logic alarm_r;

  // Alarm flag is captured together with the time snapshot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_r <= 1'b0;
    end else if (state_r == S_IDLE && send) begin
      alarm_r <= alarm_on;
    end else begin
      alarm_r <= alarm_r;
    end
  end

  assign tag_s = alarm_r;
`else
  assign tag_s = 1'b0;
`endif

  assign bit_end_s  = (baud_cnt_r == BAUD_LAST);
  assign last_idx_s = tag_s ? 4'd10 : 4'd9;

  // Character selection from the snapshot; the tag shifts CR/LF one slot later.
  always_comb begin
    hour_dec_s = dec_digits(hour_r);
    min_dec_s  = dec_digits(min_r);
    sec_dec_s  = dec_digits(sec_r);
    pos_s      = char_idx_r;
    char_s     = 8'h0A;
    if (tag_s && char_idx_r == 4'd8) begin
      char_s = 8'h2A;
    end else begin
      if (tag_s && char_idx_r > 4'd8) begin
        pos_s = char_idx_r - 4'd1;
      end else begin
        pos_s = char_idx_r;
      end
      case (pos_s)
        4'd0:    char_s = ascii_digit(hour_dec_s[7:4]);
        4'd1:    char_s = ascii_digit(hour_dec_s[3:0]);
        4'd2:    char_s = 8'h3A;
        4'd3:    char_s = ascii_digit(min_dec_s[7:4]);
        4'd4:    char_s = ascii_digit(min_dec_s[3:0]);
        4'd5:    char_s = 8'h3A;
        4'd6:    char_s = ascii_digit(sec_dec_s[7:4]);
        4'd7:    char_s = ascii_digit(sec_dec_s[3:0]);
        4'd8:    char_s = 8'h0D;
        4'd9:    char_s = 8'h0A;
        default: char_s = 8'h0A;
      endcase
    end
  end

  // Message FSM with registered tx/busy/done; the start bit is driven on the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r  <= 3'd0;
      char_idx_r <= 4'd0;
      shift_r    <= 8'h00;
      hour_r     <= 7'd0;
      min_r      <= 7'd0;
      sec_r      <= 7'd0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          baud_cnt_r <= {CNT_W{1'b0}};
          bit_cnt_r  <= 3'd0;
          done       <= 1'b0;
          if (send) begin
            hour_r     <= Hour_in;
            min_r      <= Min_in;
            sec_r      <= Sec_in;
            char_idx_r <= 4'd0;
            busy       <= 1'b1;
            tx         <= 1'b0;
            state_r    <= S_START;
          end else begin
            busy <= 1'b0;
            tx   <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            shift_r    <= char_s;
            tx         <= char_s[0];
            bit_cnt_r  <= 3'd0;
            state_r    <= S_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            if (bit_cnt_r == 3'd7) begin
              tx      <= 1'b1;
              state_r <= S_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx        <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= {CNT_W{1'b0}};
            if (char_idx_r == last_idx_s) begin
              done    <= 1'b1;
              state_r <= S_FIN;
            end else begin
              char_idx_r <= char_idx_r + 4'd1;
              tx         <= 1'b0;
              state_r    <= S_START;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          tx      <= 1'b1;
          state_r <= S_IDLE;
        end
        default: begin
          baud_cnt_r <= {CNT_W{1'b0}};
          bit_cnt_r  <= 3'd0;
          char_idx_r <= 4'd0;
          tx         <= 1'b1;
          busy       <= 1'b0;
          done       <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
